// File: rtl/regfile_wb_arbiter.sv
// Round-robin write-back arbiter for the register file's single write port,
// with read-after-write forwarding hits for the two read ports.
module regfile_wb_arbiter #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int N_REQ  = 3,
   localparam int ID_W  = $clog2(N_REQ)
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [N_REQ-1:0]          req_valid,
   input  logic [N_REQ*ADDR_W-1:0]   req_addr,
   input  logic [N_REQ*DATA_W-1:0]   req_data,
   output logic [N_REQ-1:0]          req_ready,
   input  logic                      stall,
   output logic                      w_en,
   output logic [ADDR_W-1:0]         w_addr,
   output logic [DATA_W-1:0]         w_data,
   output logic [ID_W-1:0]           grant_id,
   input  logic [ADDR_W-1:0]         ra_addr,
   input  logic [ADDR_W-1:0]         rb_addr,
   output logic                      ra_fwd_hit,
   output logic                      rb_fwd_hit,
   output logic [DATA_W-1:0]         fwd_data
);

   logic [ID_W-1:0]   rr_ptr;
   logic [ID_W-1:0]   win_idx;
   logic              win_found;
   logic              xfer;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_data;

   // Scan from rr_ptr upward, wrapping; first valid requester wins.
   always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      for (int k = 0; k < N_REQ; k++) begin
         int idx;
         idx = (int'(rr_ptr) + k) % N_REQ;
         if (!win_found && req_valid[idx]) begin
            win_found = 1'b1;
            win_idx   = ID_W'(idx);
         end
      end
   end

   // Held low during reset so no requester believes it was accepted.
   assign xfer     = win_found && !stall && !rst;
   assign sel_addr = req_addr[win_idx*ADDR_W +: ADDR_W];
   assign sel_data = req_data[win_idx*DATA_W +: DATA_W];

   always_comb begin
      req_ready = '0;
      if (xfer)
         req_ready[win_idx] = 1'b1;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         w_en     <= 1'b0;
         w_addr   <= '0;
         w_data   <= '0;
         grant_id <= '0;
         rr_ptr   <= '0;
      end else if (xfer) begin
         w_en     <= (sel_addr != '0);
         w_addr   <= sel_addr;
         w_data   <= sel_data;
         grant_id <= win_idx;
         rr_ptr   <= (win_idx == ID_W'(N_REQ-1)) ? '0 : win_idx + ID_W'(1);
      end else begin
         w_en     <= 1'b0;
      end
   end

   assign ra_fwd_hit = w_en && (w_addr == ra_addr);
   assign rb_fwd_hit = w_en && (w_addr == rb_addr);
   assign fwd_data   = w_data;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// behavioural arbiter/register-file model.
module tb_regfile_wb_arbiter;

   localparam int DW = 32;
   localparam int AW = 5;
   localparam int NR = 3;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic [NR-1:0]  req_valid = '0;
   logic [NR*AW-1:0] req_addr = '0;
   logic [NR*DW-1:0] req_data = '0;
   logic [NR-1:0]  req_ready;
   logic           stall = 1'b0;
   logic           w_en;
   logic [AW-1:0]  w_addr;
   logic [DW-1:0]  w_data;
   logic [1:0]     grant_id;
   logic [AW-1:0]  ra_addr = '0;
   logic [AW-1:0]  rb_addr = '0;
   logic           ra_fwd_hit, rb_fwd_hit;
   logic [DW-1:0]  fwd_data;

   regfile_wb_arbiter #(.DATA_W(DW), .ADDR_W(AW), .N_REQ(NR)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_addr(req_addr),
      .req_data(req_data), .req_ready(req_ready), .stall(stall), .w_en(w_en),
      .w_addr(w_addr), .w_data(w_data), .grant_id(grant_id), .ra_addr(ra_addr),
      .rb_addr(rb_addr), .ra_fwd_hit(ra_fwd_hit), .rb_fwd_hit(rb_fwd_hit),
      .fwd_data(fwd_data)
   );

   always #5 clk = ~clk;

   int n_pass = 0;
   int n_total = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
   endtask

   // Behavioural model: pointer, registered write, register file contents.
   int            m_ptr;
   logic          m_wen;
   logic [AW-1:0] m_waddr;
   logic [DW-1:0] m_wdata;
   int            m_gid;
   int            last_xfer = -1;
   logic [DW-1:0] m_rf [32];

   function automatic int pick(input logic [NR-1:0] v, input int ptr);
      for (int k = 0; k < NR; k++)
         if (v[(ptr + k) % NR]) return (ptr + k) % NR;
      return -1;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_ptr = 0; m_wen = 0; m_waddr = '0; m_wdata = '0; m_gid = 0;
         last_xfer = -1;
      end else begin
         int w;
         if (m_wen) m_rf[m_waddr] = m_wdata;
         w = stall ? -1 : pick(req_valid, m_ptr);
         last_xfer = w;
         if (w >= 0) begin
            m_waddr = req_addr[w*AW +: AW];
            m_wdata = req_data[w*DW +: DW];
            m_wen   = (m_waddr != 0);
            m_gid   = w;
            m_ptr   = (w + 1) % NR;
         end else begin
            m_wen = 0;
         end
      end
   end

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (!rst) begin
         int w;
         logic [NR-1:0] exp_rdy;
         w = stall ? -1 : pick(req_valid, m_ptr);
         exp_rdy = '0;
         if (w >= 0) exp_rdy[w] = 1'b1;
         chk("cmp_req_ready", 64'(req_ready), 64'(exp_rdy));
         chk("cmp_w_en", 64'(w_en), 64'(m_wen));
         chk("cmp_w_addr", 64'(w_addr), 64'(m_waddr));
         chk("cmp_w_data", 64'(w_data), 64'(m_wdata));
         chk("cmp_grant_id", 64'(grant_id), 64'(m_gid));
         chk("cmp_ra_hit", 64'(ra_fwd_hit), 64'(m_wen && m_waddr == ra_addr));
         chk("cmp_rb_hit", 64'(rb_fwd_hit), 64'(m_wen && m_waddr == rb_addr));
         chk("cmp_fwd_data", 64'(fwd_data), 64'(m_wdata));
      end
   end

   task automatic set_req(input int i, input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d);
      req_valid[i] = v;
      req_addr[i*AW +: AW] = a;
      req_data[i*DW +: DW] = d;
   endtask

   task automatic step();
      @(posedge clk); #1;
   endtask

   initial begin
      for (int i = 0; i < 32; i++) m_rf[i] = '0;

      // Reset state
      @(negedge clk);
      chk("rst_req_ready", 64'(req_ready), 64'h0);
      chk("rst_w_en", 64'(w_en), 64'h0);
      chk("rst_w_addr", 64'(w_addr), 64'h0);
      chk("rst_w_data", 64'(w_data), 64'h0);
      chk("rst_grant_id", 64'(grant_id), 64'h0);
      step(); rst = 1'b0;

      // Single write from requester 1
      set_req(1, 1'b1, 5'd7, 32'hDEADBEEF);
      @(negedge clk);
      chk("t1_ready", 64'(req_ready), 64'b010);
      step(); set_req(1, 1'b0, 5'd0, 32'h0);
      @(negedge clk);
      chk("t1_w_en", 64'(w_en), 64'h1);
      chk("t1_w_addr", 64'(w_addr), 64'd7);
      chk("t1_w_data", 64'(w_data), 64'hDEADBEEF);
      chk("t1_grant", 64'(grant_id), 64'd1);
      step();
      chk("t1_rf7", 64'(m_rf[7]), 64'hDEADBEEF);

      // Fresh reset, then all three valid for six cycles
      rst = 1'b1; #1; rst = 1'b0;
      for (int i = 0; i < NR; i++) set_req(i, 1'b1, AW'(i + 1), DW'(32'hA0 + i));
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         chk("t2_ready", 64'(req_ready), 64'(1 << (c % 3)));
         if (c > 0) begin
            chk("t2_w_en", 64'(w_en), 64'h1);
            chk("t2_grant", 64'(grant_id), 64'((c - 1) % 3));
         end
         step();
      end
      req_valid = '0;
      @(negedge clk);
      chk("t2_last_w_en", 64'(w_en), 64'h1);
      chk("t2_last_grant", 64'(grant_id), 64'd2);

      // Zero-address drop from requester 2
      step(); set_req(2, 1'b1, 5'd0, 32'h55);
      @(negedge clk);
      chk("t3_ready", 64'(req_ready), 64'b100);
      step(); set_req(2, 1'b0, 5'd0, 32'h0);
      @(negedge clk);
      chk("t3_w_en", 64'(w_en), 64'h0);
      chk("t3_grant", 64'(grant_id), 64'd2);
      step();
      chk("t3_rf0", 64'(m_rf[0]), 64'h0);

      // Stall holds off two requesters for three cycles
      stall = 1'b1;
      set_req(0, 1'b1, 5'd10, 32'h1010);
      set_req(1, 1'b1, 5'd11, 32'h1111);
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("t4_stall_ready", 64'(req_ready), 64'h0);
         chk("t4_stall_w_en", 64'(w_en), 64'h0);
         step();
      end
      stall = 1'b0;
      @(negedge clk);
      chk("t4_ready0", 64'(req_ready), 64'b001);
      step(); set_req(0, 1'b0, 5'd0, 32'h0);
      @(negedge clk);
      chk("t4_ready1", 64'(req_ready), 64'b010);
      chk("t4_grant0", 64'(grant_id), 64'd0);
      step(); set_req(1, 1'b0, 5'd0, 32'h0);
      @(negedge clk);
      chk("t4_grant1", 64'(grant_id), 64'd1);
      chk("t4_w_addr", 64'(w_addr), 64'd11);

      // Forwarding hits on both ports, then B moves away
      step();
      set_req(0, 1'b1, 5'd4, 32'h1234);
      ra_addr = 5'd4; rb_addr = 5'd4;
      step(); set_req(0, 1'b0, 5'd0, 32'h0);
      @(negedge clk);
      chk("t5_ra_hit", 64'(ra_fwd_hit), 64'h1);
      chk("t5_rb_hit", 64'(rb_fwd_hit), 64'h1);
      chk("t5_fwd_data", 64'(fwd_data), 64'h1234);
      #2 rb_addr = 5'd5;
      #1;
      chk("t5_rb_miss", 64'(rb_fwd_hit), 64'h0);
      chk("t5_ra_still", 64'(ra_fwd_hit), 64'h1);

      // Async reset while a write is pending
      step();
      set_req(0, 1'b1, 5'd9, 32'hAAAA);
      step(); set_req(0, 1'b0, 5'd0, 32'h0);
      #1;
      chk("t6_pending", 64'(w_en), 64'h1);
      rst = 1'b1;
      #1;
      chk("t6_w_en", 64'(w_en), 64'h0);
      chk("t6_w_addr", 64'(w_addr), 64'h0);
      chk("t6_w_data", 64'(w_data), 64'h0);
      step(); rst = 1'b0;
      chk("t6_rf9", 64'(m_rf[9]), 64'h0);

      // Randomized traffic: requests held until the model says they transferred
      for (int c = 0; c < 500; c++) begin
         step();
         for (int i = 0; i < NR; i++) begin
            if (last_xfer == i) req_valid[i] = 1'b0;
            if (!req_valid[i] && ($urandom % 2 == 0))
               set_req(i, 1'b1, AW'($urandom % 8), DW'($urandom));
         end
         stall   = ($urandom % 4 == 0);
         ra_addr = AW'($urandom % 8);
         rb_addr = AW'($urandom % 8);
      end
      step();
      req_valid = '0;
      stall = 1'b0;
      @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter for the CPU register file's single write port. Up to N_REQ producers (ALU, load unit, multiply/divide) present write requests with a valid/ready handshake; the block grants one per cycle round-robin, registers the winner onto the register file's `w_en`/`w_addr`/`w_data` inputs, and drops writes to register 0. It also reports read-after-write forwarding hits for the two read ports while a registered write is pending.

## Interface
- `DATA_W`, default 32, write data width; must match the register file word width.
- `ADDR_W`, default 5, register address width.
- `N_REQ`, default 3, number of requesters; legal range 2..8.
- `clk`, input, 1, clock; all state updates on rising edge.
- `rst`, input, 1, reset, asynchronous, active-high.
- `req_valid`, input, N_REQ, bit i set means requester i has a write pending.
- `req_addr`, input, N_REQ*ADDR_W, requester i address in bits [i*ADDR_W +: ADDR_W].
- `req_data`, input, N_REQ*DATA_W, requester i data in bits [i*DATA_W +: DATA_W].
- `req_ready`, output, N_REQ, one-hot or zero; bit i set means requester i is accepted this cycle.
- `stall`, input, 1, pipeline hold; blocks all acceptance while high.
- `w_en`, output, 1, register file write enable, registered.
- `w_addr`, output, ADDR_W, register file write address, registered.
- `w_data`, output, DATA_W, register file write data, registered.
- `grant_id`, output, clog2(N_REQ), index of the last accepted requester, registered.
- `ra_addr`, input, ADDR_W, read port A address, mirrored from the register file.
- `rb_addr`, input, ADDR_W, read port B address.
- `ra_fwd_hit`, output, 1, pending write targets `ra_addr`.
- `rb_fwd_hit`, output, 1, pending write targets `rb_addr`.
- `fwd_data`, output, DATA_W, value to forward; equals `w_data`.

## Operation
- Round-robin pointer `rr_ptr` is in the range 0..N_REQ-1.
  - Priority order each cycle: `rr_ptr`, `rr_ptr`+1, … wrapping modulo N_REQ.
  - The first requester with `req_valid` set wins.
- `req_ready` is combinational. When `stall`=0 and some valid bit is set, it is the one-hot winner; otherwise it is 0.
  - It never depends on `req_ready` of another cycle.
- A transfer occurs for requester i when `req_valid[i]` and `req_ready[i]` are both set.
- Requesters hold valid, address and data stable until their transfer. Valid is never withdrawn before it.
- On a transfer from requester i:
  - `w_addr` and `w_data` take the request fields.
  - `grant_id` takes i.
  - `rr_ptr` becomes (i+1) mod N_REQ.
  - `w_en` is set to 1 only if the address is nonzero.
- Address 0 is dropped silently: it is still acknowledged, but `w_en` is 0 next cycle.
- No transfer: `w_en` is 0 next cycle. `w_addr`, `w_data`, `grant_id` and `rr_ptr` hold.
- `w_en` is a one-cycle pulse per accepted write. The register file commits on the edge that ends that cycle.
- Forwarding (combinational):
  - `ra_fwd_hit` = `w_en` & (`w_addr` == `ra_addr`); `rb_fwd_hit` is the same with `rb_addr`.
  - Both hits may assert together.
  - `fwd_data` = `w_data`.
- Reset (async, high): `w_en`=0, `w_addr`=0, `w_data`=0, `grant_id`=0, `rr_ptr`=0.
  - `req_ready`, `ra_fwd_hit` and `rb_fwd_hit` are therefore 0 while `rst` is high.
  - A write in flight when reset asserts is lost.
  - The first grant after reset release favours requester 0.

## Timing
- Latency: transfer at edge E; `w_en`/`w_addr`/`w_data` are valid in the cycle after E; the register file write happens at edge E+1.
- Throughput is one write per cycle. Back-to-back grants to different requesters produce consecutive `w_en` pulses.
- A requester held valid is granted within N_REQ cycles of `stall` deasserting. No starvation.
- `stall` asserted in the same cycle as valid gives no transfer. A pending `w_en` still completes; `stall` never extends or suppresses it.
- Single requester continuously valid: granted every cycle. `rr_ptr` stays at (i+1) mod N_REQ, which still yields i.

## Test plan
- Reset, then one write: requester 1 sends valid, addr 7, data 0xDEADBEEF → `req_ready`=3'b010 the same cycle; next cycle `w_en`=1, `w_addr`=7, `w_data`=0xDEADBEEF, `grant_id`=1; register 7 reads 0xDEADBEEF after the following edge.
- All three requesters valid for 6 cycles after reset, addresses 1/2/3 → grant order 0,1,2,0,1,2; six consecutive `w_en` pulses.
- Zero-address drop: requester 2 sends addr 0, data 0x55 → `req_ready[2]`=1; next cycle `w_en`=0; `grant_id`=2; register 0 remains 0.
- Stall: requesters 0 and 1 valid with `stall`=1 for 3 cycles → `req_ready`=0 and `w_en`=0 throughout; after release, requester 0 is granted, then 1.
- Forwarding: accept a write to addr 4 (0x1234) while `ra_addr`=4 and `rb_addr`=4 next cycle → `ra_fwd_hit`=`rb_fwd_hit`=1, `fwd_data`=0x1234; with `rb_addr`=5, `rb_fwd_hit`=0.
- Async reset during a pending write: assert `rst` mid-cycle while `w_en`=1 → `w_en`, `w_addr`, `w_data` go to 0 immediately without waiting for a clock edge; no register file write occurs.
